// File: rtl/parking_entry_frontend.sv
// parking_entry_frontend
//   Conditions the raw entry/exit lane sensors for the car_parking gate
//   controller, captures and holds the 2-bit keypad password, and tracks how
//   many cars are inside the lot.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   raw_entry  in   asynchronous entry-lane sensor (1 = car present)
//   raw_exit   in   asynchronous exit-lane sensor (1 = car present)
//   key_data   in   keypad password value, sampled when key_valid=1
//   key_valid  in   single-cycle keypad strobe
//   sen_entry  out  debounced entry presence, withheld while the lot is full
//   sen_exit   out  debounced exit presence
//   password   out  held password, 0 when none is held
//   pw_ready   out  1 while a password is held
//   occupancy  out  cars currently inside, 0..CAPACITY
//   lot_full   out  occupancy == CAPACITY
//   lot_empty  out  occupancy == 0
module parking_entry_frontend #(
   parameter int CAPACITY   = 8,
   parameter int DEBOUNCE   = 4,
   parameter int PW_TIMEOUT = 64,
   parameter int CW         = $clog2(CAPACITY + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          raw_entry,
   input  logic          raw_exit,
   input  logic [1:0]    key_data,
   input  logic          key_valid,
   output logic          sen_entry,
   output logic          sen_exit,
   output logic [1:0]    password,
   output logic          pw_ready,
   output logic [CW-1:0] occupancy,
   output logic          lot_full,
   output logic          lot_empty
);

   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int TW = (PW_TIMEOUT > 1) ? $clog2(PW_TIMEOUT) : 1;
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);
   localparam logic [TW-1:0] TMR_LAST = TW'(PW_TIMEOUT - 1);
   localparam logic [CW-1:0] OCC_MAX  = CW'(CAPACITY);

   typedef enum logic {
      PW_IDLE = 1'b0,
      PW_HELD = 1'b1
   } pw_state_t;

   // Channel 0 is the entry lane, channel 1 the exit lane.
   logic [1:0] raw;
   logic [1:0] deb;
   logic [1:0] fall;

   assign raw = {raw_exit, raw_entry};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sensor
         logic          sync1_reg;
         logic          sync2_reg;
         logic          deb_reg;
         logic          deb_d_reg;
         logic [DW-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               deb_reg   <= 1'b0;
               deb_d_reg <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= raw[gi];
               sync2_reg <= sync1_reg;
               deb_d_reg <= deb_reg;
               // The level flips only once the counter has already recorded
               // DEBOUNCE disagreeing cycles and the input still disagrees,
               // so any shorter glitch resets the count before it matters.
               if (sync2_reg == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DEB_MAX) begin
                  deb_reg <= ~deb_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign deb[gi]  = deb_reg;
         // Car has left the sensor: debounced level was high last cycle.
         assign fall[gi] = deb_d_reg & ~deb_reg;
      end
   endgenerate

   // Occupancy counter, saturating at both ends; a simultaneous entry and
   // exit cancel out.
   logic [CW-1:0] occ_reg;
   logic [CW-1:0] occ_next;

   always_comb begin
      occ_next = occ_reg;
      if (fall[0] && !fall[1] && (occ_reg != OCC_MAX)) begin
         occ_next = occ_reg + 1'b1;
      end else if (fall[1] && !fall[0] && (occ_reg != '0)) begin
         occ_next = occ_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_reg <= '0;
      end else begin
         occ_reg <= occ_next;
      end
   end

   // Password hold FSM
   pw_state_t     state_reg;
   pw_state_t     state_next;
   logic [1:0]    pw_reg;
   logic [1:0]    pw_next;
   logic [TW-1:0] timer_reg;
   logic [TW-1:0] timer_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= PW_IDLE;
         pw_reg    <= 2'b00;
         timer_reg <= '0;
      end else begin
         state_reg <= state_next;
         pw_reg    <= pw_next;
         timer_reg <= timer_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pw_next    = pw_reg;
      timer_next = timer_reg;
      case (state_reg)
         PW_IDLE: begin
            if (key_valid) begin
               state_next = PW_HELD;
               pw_next    = key_data;
               timer_next = '0;
            end
         end
         PW_HELD: begin
            // A fresh key press outranks both release conditions.
            if (key_valid) begin
               pw_next    = key_data;
               timer_next = '0;
            end else if (fall[0] || (timer_reg == TMR_LAST)) begin
               state_next = PW_IDLE;
               pw_next    = 2'b00;
               timer_next = '0;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         default: begin
            state_next = PW_IDLE;
            pw_next    = 2'b00;
            timer_next = '0;
         end
      endcase
   end

   assign lot_full  = (occ_reg == OCC_MAX);
   assign lot_empty = (occ_reg == '0);
   assign occupancy = occ_reg;
   assign sen_entry = deb[0] & ~lot_full;
   assign sen_exit  = deb[1];
   assign password  = pw_reg;
   assign pw_ready  = (state_reg == PW_HELD);

endmodule

// File: tb/tb_parking_entry_frontend.sv
// tb_parking_entry_frontend
//   Scoreboard bench for parking_entry_frontend. Stimulus pushes expected
//   output values tagged with the clock cycle they must appear in; a monitor
//   on the falling edge pops and compares every entry due in that cycle.
module tb_parking_entry_frontend;

   localparam int CAP = 8;
   localparam int CW  = $clog2(CAP + 1);

   localparam int S_SEN_ENTRY = 0;
   localparam int S_SEN_EXIT  = 1;
   localparam int S_PASSWORD  = 2;
   localparam int S_PW_READY  = 3;
   localparam int S_OCC       = 4;
   localparam int S_FULL      = 5;
   localparam int S_EMPTY     = 6;

   typedef struct {
      int cyc;
      int sig;
      int val;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          raw_entry = 1'b0;
   logic          raw_exit = 1'b0;
   logic [1:0]    key_data = 2'b00;
   logic          key_valid = 1'b0;
   logic          sen_entry;
   logic          sen_exit;
   logic [1:0]    password;
   logic          pw_ready;
   logic [CW-1:0] occupancy;
   logic          lot_full;
   logic          lot_empty;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   occ_m = 0;
   bit   finish_req = 1'b0;
   exp_t sb_q[$];

   parking_entry_frontend #(
      .CAPACITY  (CAP),
      .DEBOUNCE  (4),
      .PW_TIMEOUT(64)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .raw_entry (raw_entry),
      .raw_exit  (raw_exit),
      .key_data  (key_data),
      .key_valid (key_valid),
      .sen_entry (sen_entry),
      .sen_exit  (sen_exit),
      .password  (password),
      .pw_ready  (pw_ready),
      .occupancy (occupancy),
      .lot_full  (lot_full),
      .lot_empty (lot_empty)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sample(input int sig);
      case (sig)
         S_SEN_ENTRY: return int'(sen_entry);
         S_SEN_EXIT:  return int'(sen_exit);
         S_PASSWORD:  return int'(password);
         S_PW_READY:  return int'(pw_ready);
         S_OCC:       return int'(occupancy);
         S_FULL:      return int'(lot_full);
         S_EMPTY:     return int'(lot_empty);
         default:     return -1;
      endcase
   endfunction

   function automatic string sig_name(input int sig);
      case (sig)
         S_SEN_ENTRY: return "sen_entry";
         S_SEN_EXIT:  return "sen_exit";
         S_PASSWORD:  return "password";
         S_PW_READY:  return "pw_ready";
         S_OCC:       return "occupancy";
         S_FULL:      return "lot_full";
         S_EMPTY:     return "lot_empty";
         default:     return "unknown";
      endcase
   endfunction

   // Monitor: compare every expectation due this cycle, away from the edge.
   always @(negedge clk) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == cyc) begin
            int act;
            act = sample(sb_q[i].sig);
            checks++;
            if (act != sb_q[i].val) begin
               errors++;
               $display("FAIL %s cyc=%0d got=%0d want=%0d",
                        sig_name(sb_q[i].sig), cyc, act, sb_q[i].val);
            end
            sb_q.delete(i);
         end
      end
      if (finish_req || cyc > 20000) begin
         if (!finish_req) begin
            checks++;
            errors++;
            $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
         end
         foreach (sb_q[i]) begin
            checks++;
            errors++;
            $display("FAIL %s_unchecked cyc=%0d got=none want=%0d",
                     sig_name(sb_q[i].sig), sb_q[i].cyc, sb_q[i].val);
         end
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic push_exp(input int d, input int sig, input int val);
      exp_t e;
      e.cyc = cyc + d;
      e.sig = sig;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic key_press(input logic [1:0] kv);
      key_valid = 1'b1;
      key_data  = kv;
      step();
      key_valid = 1'b0;
   endtask

   // One car passage through the entry lane, the exit lane, or both at once,
   // with the sensors held for 'hold' cycles. Optionally strobes the keypad
   // after the key_at-th step.
   task automatic pass(input int hold, input bit en, input bit ex,
                       input int key_at, input logic [1:0] kv);
      int nxt;
      int open;
      nxt  = occ_m;
      open = (occ_m < CAP) ? 1 : 0;
      if (en && !ex && occ_m < CAP) nxt = occ_m + 1;
      if (ex && !en && occ_m > 0)   nxt = occ_m - 1;
      if (en) begin
         push_exp(6, S_SEN_ENTRY, 0);
         push_exp(7, S_SEN_ENTRY, open);
         push_exp(hold + 6, S_SEN_ENTRY, open);
         push_exp(hold + 7, S_SEN_ENTRY, 0);
      end
      if (ex) begin
         push_exp(6, S_SEN_EXIT, 0);
         push_exp(7, S_SEN_EXIT, 1);
         push_exp(hold + 6, S_SEN_EXIT, 1);
         push_exp(hold + 7, S_SEN_EXIT, 0);
      end
      push_exp(hold + 7, S_OCC, occ_m);
      push_exp(hold + 8, S_OCC, nxt);
      push_exp(hold + 8, S_FULL, (nxt == CAP) ? 1 : 0);
      push_exp(hold + 8, S_EMPTY, (nxt == 0) ? 1 : 0);
      for (int i = 0; i < hold + 10; i++) begin
         if (en) raw_entry = (i < hold);
         if (ex) raw_exit  = (i < hold);
         key_valid = (i == key_at);
         key_data  = kv;
         step();
      end
      key_valid = 1'b0;
      $display("passage entry=%0b exit=%0b occupancy %0d -> %0d", en, ex, occ_m, nxt);
      occ_m = nxt;
   endtask

   initial begin
      // Reset state
      run(2);
      push_exp(0, S_SEN_ENTRY, 0);
      push_exp(0, S_SEN_EXIT, 0);
      push_exp(0, S_PASSWORD, 0);
      push_exp(0, S_PW_READY, 0);
      push_exp(0, S_OCC, 0);
      push_exp(0, S_FULL, 0);
      push_exp(0, S_EMPTY, 1);
      reset = 1'b0;
      run(2);

      // 3-cycle glitches on the entry sensor never reach sen_entry
      for (int d = 1; d <= 30; d++) push_exp(d, S_SEN_ENTRY, 0);
      push_exp(30, S_OCC, 0);
      push_exp(30, S_EMPTY, 1);
      for (int p = 0; p < 4; p++) begin
         raw_entry = 1'b1;
         run(3);
         raw_entry = 1'b0;
         run(3);
      end
      run(8);
      $display("glitch train on raw_entry done");

      // First full entry passage: 0 -> 1
      pass(10, 1'b1, 1'b0, -1, 2'b00);

      // Keypad 01, held for exactly 64 cycles
      push_exp(0, S_PW_READY, 0);
      push_exp(1, S_PASSWORD, 1);
      push_exp(1, S_PW_READY, 1);
      push_exp(64, S_PASSWORD, 1);
      push_exp(64, S_PW_READY, 1);
      push_exp(65, S_PASSWORD, 0);
      push_exp(65, S_PW_READY, 0);
      key_press(2'b01);
      run(80);
      $display("keypad 01 hold/timeout done");

      // Keypad 01 then 11 thirty cycles later restarts the timer
      key_press(2'b01);
      run(29);
      push_exp(1, S_PASSWORD, 3);
      push_exp(35, S_PW_READY, 1);
      push_exp(64, S_PW_READY, 1);
      push_exp(65, S_PW_READY, 0);
      push_exp(65, S_PASSWORD, 0);
      key_press(2'b11);
      run(80);
      $display("keypad reload done");

      // Password released by an entry completion
      push_exp(1, S_PASSWORD, 2);
      key_press(2'b10);
      push_exp(17, S_PASSWORD, 2);
      push_exp(17, S_PW_READY, 1);
      push_exp(18, S_PASSWORD, 0);
      push_exp(18, S_PW_READY, 0);
      pass(10, 1'b1, 1'b0, -1, 2'b00);

      // Key strobe coincident with the entry completion wins
      key_press(2'b01);
      push_exp(18, S_PASSWORD, 3);
      push_exp(18, S_PW_READY, 1);
      push_exp(19, S_PASSWORD, 3);
      push_exp(81, S_PW_READY, 1);
      push_exp(82, S_PW_READY, 0);
      pass(10, 1'b1, 1'b0, 17, 2'b11);
      run(70);

      // Fill the lot
      repeat (5) pass(10, 1'b1, 1'b0, -1, 2'b00);

      // Ninth car waits at the entry while full; an exit lets it through
      raw_entry = 1'b1;
      push_exp(7, S_SEN_ENTRY, 0);
      push_exp(10, S_SEN_ENTRY, 0);
      push_exp(12, S_OCC, 8);
      run(12);
      push_exp(17, S_SEN_ENTRY, 0);
      push_exp(18, S_SEN_ENTRY, 1);
      pass(10, 1'b0, 1'b1, -1, 2'b00);
      push_exp(6, S_SEN_ENTRY, 1);
      push_exp(7, S_SEN_ENTRY, 0);
      push_exp(7, S_OCC, 7);
      push_exp(8, S_OCC, 8);
      push_exp(8, S_FULL, 1);
      raw_entry = 1'b0;
      run(10);
      occ_m = 8;
      $display("ninth car admitted after exit, occupancy 8");

      // Simultaneous entry and exit at capacity
      pass(10, 1'b1, 1'b1, -1, 2'b00);

      // Drain, then underflow and simultaneous passages at zero
      repeat (8) pass(10, 1'b0, 1'b1, -1, 2'b00);
      pass(10, 1'b0, 1'b1, -1, 2'b00);
      pass(10, 1'b1, 1'b1, -1, 2'b00);

      // Reset mid-debounce with occupancy 5 and a held password
      repeat (5) pass(10, 1'b1, 1'b0, -1, 2'b00);
      key_press(2'b10);
      raw_entry = 1'b1;
      run(4);
      push_exp(0, S_OCC, 5);
      push_exp(0, S_PW_READY, 1);
      push_exp(0, S_PASSWORD, 2);
      push_exp(0, S_SEN_ENTRY, 0);
      push_exp(1, S_SEN_ENTRY, 0);
      push_exp(1, S_SEN_EXIT, 0);
      push_exp(1, S_PASSWORD, 0);
      push_exp(1, S_PW_READY, 0);
      push_exp(1, S_OCC, 0);
      push_exp(1, S_FULL, 0);
      push_exp(1, S_EMPTY, 1);
      reset = 1'b1;
      raw_entry = 1'b0;
      step();
      reset = 1'b0;
      occ_m = 0;
      push_exp(10, S_SEN_ENTRY, 0);
      push_exp(10, S_OCC, 0);
      push_exp(10, S_PW_READY, 0);
      run(12);
      $display("mid-operation reset done");

      finish_req = 1'b1;
      run(3);
   end

endmodule
